// File: rtl/irq_ctrl_pkg.sv
// Shared cause codes, FSM encodings and priority helpers for the machine interrupt controller.
package irq_ctrl_pkg;

    typedef logic [3:0] cause_t;
    typedef logic [2:0] irq_vec_t;

    localparam cause_t CAUSE_NONE = 4'd0;
    localparam cause_t CAUSE_MSI  = 4'd3;
    localparam cause_t CAUSE_MTI  = 4'd7;
    localparam cause_t CAUSE_MEI  = 4'd11;

    localparam int MSI_BIT = 0;
    localparam int MTI_BIT = 1;
    localparam int MEI_BIT = 2;

    localparam logic [1:0] IRQ_IDLE    = 2'd0;
    localparam logic [1:0] IRQ_REQ     = 2'd1;
    localparam logic [1:0] IRQ_SERVICE = 2'd2;

    // Fixed machine-level priority: external, then software, then timer.
    function automatic cause_t prio_cause(input irq_vec_t v);
        if (v[MEI_BIT])      return CAUSE_MEI;
        else if (v[MSI_BIT]) return CAUSE_MSI;
        else if (v[MTI_BIT]) return CAUSE_MTI;
        else                 return CAUSE_NONE;
    endfunction

    function automatic irq_vec_t cause_mask(input cause_t c);
        case (c)
            CAUSE_MEI: return 3'b100;
            CAUSE_MTI: return 3'b010;
            CAUSE_MSI: return 3'b001;
            default:   return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Controller-to-pipeline trap interface: request/cause/mip out, ack/mret back.
interface irq_ctrl_if;
    import irq_ctrl_pkg::*;

    logic     irq_req;
    cause_t   irq_cause;
    irq_vec_t mip;
    logic     irq_ack;
    logic     mret;

    modport master (output irq_req, output irq_cause, output mip,
                    input  irq_ack, input  mret);
    modport slave  (input  irq_req, input  irq_cause, input  mip,
                    output irq_ack, output mret);
endinterface

// File: rtl/irq_ctrl_sync.sv
// N-flop synchronizer with synchronous reset to 0; output lags input by N cycles.
module irq_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);
    logic [N-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[N-2:0], d_i};
    end

    assign q_o = sync_q[N-1];
endmodule

// File: rtl/irq_ctrl.sv
// Machine interrupt controller: registered MIP, masking, fixed priority, one held request.
// Source to irq_req is 2 cycles (pad adds EXT_SYNC); request held until ack, no nesting until mret.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int EXT_SYNC = 2,
    parameter int EXT_EDGE = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          timer_irq,
    input  logic          sw_irq,
    input  logic          ex_irq,
    input  logic          ext_irq_pin,
    input  logic          mstatus_mie,
    input  logic [2:0]    mie,
    irq_ctrl_if.master    bus
);
    logic       pin_s;
    logic       ext_s;
    logic       meip_d;
    irq_vec_t   mip_q, mip_d;
    irq_vec_t   elig;
    cause_t     win;
    logic [1:0] state_q, state_d;
    logic       req_q, req_d;
    cause_t     cause_q, cause_d;
    logic       ack_take;
    logic       frozen_ok;

    irq_sync #(.N(EXT_SYNC)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (ext_irq_pin),
        .q_o   (pin_s)
    );

    assign ext_s    = ex_irq | pin_s;
    assign ack_take = bus.irq_ack && (state_q == IRQ_REQ);

    generate
        if (EXT_EDGE != 0) begin : g_edge
            logic ext_d_q;
            logic rise;

            always_ff @(posedge clk) begin
                if (reset) ext_d_q <= 1'b0;
                else       ext_d_q <= ext_s;
            end

            // A new edge in the same cycle as the clearing ack must not be lost.
            assign rise   = ext_s & ~ext_d_q;
            assign meip_d = rise | (mip_q[MEI_BIT] & ~(ack_take && (cause_q == CAUSE_MEI)));
        end else begin : g_level
            assign meip_d = ext_s;
        end
    endgenerate

    assign mip_d     = {meip_d, timer_irq, sw_irq};
    assign elig      = mip_q & mie & {3{mstatus_mie}};
    assign win       = prio_cause(elig);
    assign frozen_ok = |(elig & cause_mask(cause_q));

    always_comb begin
        state_d = state_q;
        req_d   = 1'b0;
        cause_d = cause_q;
        case (state_q)
            IRQ_IDLE: begin
                if (|elig) begin
                    state_d = IRQ_REQ;
                    req_d   = 1'b1;
                    cause_d = win;
                end
            end
            IRQ_REQ: begin
                if (bus.irq_ack) begin
                    state_d = IRQ_SERVICE;
                end else if (!frozen_ok) begin
                    state_d = IRQ_IDLE;
                end else begin
                    req_d = 1'b1;
                end
            end
            IRQ_SERVICE: begin
                // A source still pending at mret is presented on the very next cycle.
                if (bus.mret) begin
                    if (|elig) begin
                        state_d = IRQ_REQ;
                        req_d   = 1'b1;
                        cause_d = win;
                    end else begin
                        state_d = IRQ_IDLE;
                    end
                end
            end
            default: state_d = IRQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mip_q   <= '0;
            state_q <= IRQ_IDLE;
            req_q   <= 1'b0;
            cause_q <= CAUSE_NONE;
        end else begin
            mip_q   <= mip_d;
            state_q <= state_d;
            req_q   <= req_d;
            cause_q <= cause_d;
        end
    end

    assign bus.irq_req   = req_q;
    assign bus.irq_cause = cause_q;
    assign bus.mip       = mip_q;
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench: u0 uses level MEIP, u1 uses edge MEIP; both use a 2-flop pad synchronizer.
module tb_irq_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       timer_irq = 1'b0, sw_irq = 1'b0, ex_irq = 1'b0, ext_irq_pin = 1'b0;
    logic       mstatus_mie = 1'b0;
    logic [2:0] mie = 3'b000;
    int         n_cmp = 0;
    int         n_err = 0;

    irq_ctrl_if if0();
    irq_ctrl_if if1();

    irq_ctrl #(.EXT_SYNC(2), .EXT_EDGE(0)) u0 (
        .clk(clk), .reset(reset), .timer_irq(timer_irq), .sw_irq(sw_irq), .ex_irq(ex_irq),
        .ext_irq_pin(ext_irq_pin), .mstatus_mie(mstatus_mie), .mie(mie), .bus(if0));
    irq_ctrl #(.EXT_SYNC(2), .EXT_EDGE(1)) u1 (
        .clk(clk), .reset(reset), .timer_irq(timer_irq), .sw_irq(sw_irq), .ex_irq(ex_irq),
        .ext_irq_pin(ext_irq_pin), .mstatus_mie(mstatus_mie), .mie(mie), .bus(if1));

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        {timer_irq, sw_irq, ex_irq, ext_irq_pin, mstatus_mie} = '0;
        mie = 3'b000;
        if0.irq_ack = 1'b0; if0.mret = 1'b0;
        if1.irq_ack = 1'b0; if1.mret = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (if0.irq_req !== 1'b0) begin n_err++; $display("FAIL rst_req0 got %b want 0", if0.irq_req); end
        n_cmp++; if (if0.irq_cause !== 4'd0) begin n_err++; $display("FAIL rst_cause0 got %0d want 0", if0.irq_cause); end
        n_cmp++; if (if0.mip !== 3'b000) begin n_err++; $display("FAIL rst_mip0 got %b want 000", if0.mip); end
        n_cmp++; if (if1.mip !== 3'b000) begin n_err++; $display("FAIL rst_mip1 got %b want 000", if1.mip); end
    endtask

    task automatic test_timer();
        apply_reset();
        mie = 3'b010; mstatus_mie = 1'b1;
        step();
        timer_irq = 1'b1;
        step();
        n_cmp++; if (if0.mip !== 3'b010) begin n_err++; $display("FAIL tmr_mip got %b want 010", if0.mip); end
        n_cmp++; if (if0.irq_req !== 1'b0) begin n_err++; $display("FAIL tmr_req_early got %b want 0", if0.irq_req); end
        step();
        n_cmp++; if (if0.irq_req !== 1'b1) begin n_err++; $display("FAIL tmr_req got %b want 1", if0.irq_req); end
        n_cmp++; if (if0.irq_cause !== 4'd7) begin n_err++; $display("FAIL tmr_cause got %0d want 7", if0.irq_cause); end
        step(2);
        if0.irq_ack = 1'b1;
        step();
        if0.irq_ack = 1'b0;
        n_cmp++; if (if0.irq_req !== 1'b0) begin n_err++; $display("FAIL tmr_ack_drop got %b want 0", if0.irq_req); end
        n_cmp++; if (if0.irq_cause !== 4'd7) begin n_err++; $display("FAIL tmr_cause_hold got %0d want 7", if0.irq_cause); end
        step(4);
        n_cmp++; if (if0.irq_req !== 1'b0) begin n_err++; $display("FAIL tmr_no_nest got %b want 0", if0.irq_req); end
        step();
        if0.mret = 1'b1;
        step();
        if0.mret = 1'b0;
        n_cmp++; if (if0.irq_req !== 1'b1) begin n_err++; $display("FAIL tmr_rereq got %b want 1", if0.irq_req); end
    endtask

    task automatic test_priority();
        apply_reset();
        mie = 3'b111; mstatus_mie = 1'b1;
        {timer_irq, sw_irq, ex_irq} = 3'b111;
        step(2);
        n_cmp++; if (if0.irq_cause !== 4'd11 || if0.irq_req !== 1'b1) begin n_err++; $display("FAIL pri_mei got req=%b cause=%0d want 1/11", if0.irq_req, if0.irq_cause); end
        if0.irq_ack = 1'b1; step(); if0.irq_ack = 1'b0;
        ex_irq = 1'b0;
        step(2);
        if0.mret = 1'b1; step(); if0.mret = 1'b0;
        n_cmp++; if (if0.irq_cause !== 4'd3 || if0.irq_req !== 1'b1) begin n_err++; $display("FAIL pri_msi got req=%b cause=%0d want 1/3", if0.irq_req, if0.irq_cause); end
        if0.irq_ack = 1'b1; step(); if0.irq_ack = 1'b0;
        sw_irq = 1'b0;
        step(2);
        if0.mret = 1'b1; step(); if0.mret = 1'b0;
        n_cmp++; if (if0.irq_cause !== 4'd7 || if0.irq_req !== 1'b1) begin n_err++; $display("FAIL pri_mti got req=%b cause=%0d want 1/7", if0.irq_req, if0.irq_cause); end
    endtask

    task automatic test_freeze_withdraw();
        apply_reset();
        mie = 3'b011; mstatus_mie = 1'b1;
        timer_irq = 1'b1;
        step(2);
        n_cmp++; if (if0.irq_cause !== 4'd7) begin n_err++; $display("FAIL frz_start got %0d want 7", if0.irq_cause); end
        sw_irq = 1'b1;
        step(2);
        n_cmp++; if (if0.irq_cause !== 4'd7 || if0.irq_req !== 1'b1) begin n_err++; $display("FAIL frz_hold got req=%b cause=%0d want 1/7", if0.irq_req, if0.irq_cause); end
        timer_irq = 1'b0;
        step();
        n_cmp++; if (if0.irq_req !== 1'b1) begin n_err++; $display("FAIL wd_still got %b want 1", if0.irq_req); end
        step();
        n_cmp++; if (if0.irq_req !== 1'b0) begin n_err++; $display("FAIL wd_drop got %b want 0", if0.irq_req); end
        step();
        n_cmp++; if (if0.irq_cause !== 4'd3 || if0.irq_req !== 1'b1) begin n_err++; $display("FAIL wd_msi got req=%b cause=%0d want 1/3", if0.irq_req, if0.irq_cause); end
    endtask

    task automatic test_ext_edge();
        apply_reset();
        mie = 3'b100; mstatus_mie = 1'b1;
        ext_irq_pin = 1'b1; step(); ext_irq_pin = 1'b0;
        step();
        n_cmp++; if (if1.mip !== 3'b000) begin n_err++; $display("FAIL edge_mip_early got %b want 000", if1.mip); end
        step();
        n_cmp++; if (if1.mip !== 3'b100) begin n_err++; $display("FAIL edge_mip_set got %b want 100", if1.mip); end
        step();
        n_cmp++; if (if1.irq_req !== 1'b1 || if1.irq_cause !== 4'd11) begin n_err++; $display("FAIL edge_req got req=%b cause=%0d want 1/11", if1.irq_req, if1.irq_cause); end
        step();
        n_cmp++; if (if1.mip !== 3'b100) begin n_err++; $display("FAIL edge_sticky got %b want 100", if1.mip); end
        if1.irq_ack = 1'b1; step(); if1.irq_ack = 1'b0;
        n_cmp++; if (if1.mip !== 3'b000 || if1.irq_req !== 1'b0) begin n_err++; $display("FAIL edge_clear got mip=%b req=%b want 000/0", if1.mip, if1.irq_req); end
        if1.mret = 1'b1; step(); if1.mret = 1'b0;
        ext_irq_pin = 1'b1; step(); ext_irq_pin = 1'b0;
        step(3);
        n_cmp++; if (if1.irq_req !== 1'b1) begin n_err++; $display("FAIL edge_req2 got %b want 1", if1.irq_req); end
        // Second pulse reaches the edge detector on the same edge the ack is taken.
        ext_irq_pin = 1'b1; step(); ext_irq_pin = 1'b0;
        step();
        if1.irq_ack = 1'b1; step(); if1.irq_ack = 1'b0;
        n_cmp++; if (if1.mip !== 3'b100 || if1.irq_req !== 1'b0) begin n_err++; $display("FAIL edge_set_wins got mip=%b req=%b want 100/0", if1.mip, if1.irq_req); end
    endtask

    task automatic test_global_mask();
        apply_reset();
        mie = 3'b111; mstatus_mie = 1'b0;
        {timer_irq, sw_irq, ex_irq} = 3'b111;
        step(3);
        n_cmp++; if (if0.irq_req !== 1'b0 || if0.mip !== 3'b111) begin n_err++; $display("FAIL mask_off got req=%b mip=%b want 0/111", if0.irq_req, if0.mip); end
        mstatus_mie = 1'b1;
        step(2);
        n_cmp++; if (if0.irq_req !== 1'b1 || if0.irq_cause !== 4'd11) begin n_err++; $display("FAIL mask_on got req=%b cause=%0d want 1/11", if0.irq_req, if0.irq_cause); end
        if0.mret = 1'b1; step(); if0.mret = 1'b0;
        n_cmp++; if (if0.irq_req !== 1'b1 || if0.irq_cause !== 4'd11) begin n_err++; $display("FAIL mret_in_req got req=%b cause=%0d want 1/11", if0.irq_req, if0.irq_cause); end
    endtask

    task automatic test_reset_service_idle();
        if0.irq_ack = 1'b1; step(); if0.irq_ack = 1'b0;
        n_cmp++; if (if0.irq_req !== 1'b0) begin n_err++; $display("FAIL svc_entry got %b want 0", if0.irq_req); end
        reset = 1'b1; step(); reset = 1'b0;
        n_cmp++; if (if0.irq_req !== 1'b0 || if0.mip !== 3'b000 || if0.irq_cause !== 4'd0) begin n_err++; $display("FAIL svc_reset got req=%b mip=%b cause=%0d want 0/000/0", if0.irq_req, if0.mip, if0.irq_cause); end
        {timer_irq, sw_irq, ex_irq} = 3'b000;
        mie = 3'b010;
        step(2);
        if0.irq_ack = 1'b1; step(); if0.irq_ack = 1'b0;
        if0.mret = 1'b1; step(); if0.mret = 1'b0;
        n_cmp++; if (if0.irq_req !== 1'b0) begin n_err++; $display("FAIL idle_pulses got %b want 0", if0.irq_req); end
        timer_irq = 1'b1;
        step(2);
        n_cmp++; if (if0.irq_req !== 1'b1 || if0.irq_cause !== 4'd7) begin n_err++; $display("FAIL idle_intact got req=%b cause=%0d want 1/7", if0.irq_req, if0.irq_cause); end
    endtask

    initial begin
        if0.irq_ack = 1'b0; if0.mret = 1'b0;
        if1.irq_ack = 1'b0; if1.mret = 1'b0;
        test_reset();
        test_timer();
        test_priority();
        test_freeze_withdraw();
        test_ext_edge();
        test_global_mask();
        test_reset_service_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
